// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and a parity helper.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE_WAIT = 3'd0,
        ARMED     = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5,
        DONE      = 3'd6
    } uart_state_e;

    // 1 when the received parity bit disagrees with the data word (zero-extended).
    function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                             input logic                     sample,
                                             input logic                     odd);
        return (^data) ^ sample ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pad plus falling-edge detect.
// Ports:
//   clk    in   system clock
//   res    in   asynchronous active-low reset (all flops reset to 1, idle line)
//   rx     in   raw serial input
//   rx_s   out  synchronised RX (registered)
//   fall_c out  combinational falling-edge pulse of rx_s
module uart_rx_sync (
    input  logic clk,
    input  logic res,
    input  logic rx,
    output logic rx_s,
    output logic fall_c
);

    logic rx_m;
    logic rx_d;

    // Metastability stage, stable stage, one-cycle delay for edge detect.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall_c = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with idle arming, start-bit glitch rejection,
// optional parity and 1/2 stop bits.
// Ports:
//   clk          in   system clock
//   res          in   asynchronous active-low reset
//   RX           in   serial input, idle high, asynchronous to clk
//   data_out     out  received word, updated only on the strobe cycle
//   en_data_out  out  one-cycle strobe, data_out and flags valid
//   parity_err   out  parity mismatch, valid with strobe
//   frame_err    out  a stop bit sampled low, valid with strobe
//   busy         out  frame in progress (start edge until strobe)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5000,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned IDLE_BITS    = 12
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 en_data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned HALF   = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned LAST   = CLKS_PER_BIT - 1;

    uart_state_e            state_q;
    uart_state_e            state_d;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [IDLE_W-1:0]      idle_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q;
    logic                   ferr_q;

    logic rx_s;
    logic fall_c;
    logic wrap_c;
    logic half_c;
    logic last_data_c;
    logic last_stop_c;

    uart_rx_sync u_sync (
        .clk    (clk),
        .res    (res),
        .rx     (RX),
        .rx_s   (rx_s),
        .fall_c (fall_c)
    );

    assign wrap_c      = (bit_cnt_q == CNT_W'(LAST));
    assign half_c      = (bit_cnt_q == CNT_W'(HALF));
    assign last_data_c = (idx_q == IDX_W'(DATA_BITS - 1));
    assign last_stop_c = (idx_q == IDX_W'(STOP_BITS - 1));

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; all later samples fall on bit_cnt wrap (mid-bit).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_WAIT: if (idle_cnt_q == IDLE_W'(IDLE_BITS)) state_d = ARMED;
            ARMED:     if (fall_c) state_d = START;
            START:     if (half_c) state_d = rx_s ? ARMED : DATA;
            DATA:      if (wrap_c && last_data_c) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    if (wrap_c) state_d = STOP;
            STOP:      if (wrap_c && last_stop_c) state_d = DONE;
            DONE:      state_d = ferr_q ? IDLE_WAIT : ARMED;
            default:   state_d = IDLE_WAIT;
        endcase
    end

    // Bit timing, idle counting, shift register and registered outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            data_out    <= '0;
            en_data_out <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            en_data_out <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;

            // Realign the bit clock on the start edge and again at mid start bit.
            if ((state_q == ARMED && fall_c) || (state_q == START && half_c) || wrap_c) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (state_q == DONE) begin
                idle_cnt_q <= '0;
            end else if (state_q == IDLE_WAIT && wrap_c) begin
                if (!rx_s) begin
                    idle_cnt_q <= '0;
                end else if (idle_cnt_q != IDLE_W'(IDLE_BITS)) begin
                    idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                end
            end

            // Index restarts on every state change; counts data bits and stop bits.
            if (state_d != state_q) begin
                idx_q <= '0;
            end else if (wrap_c && (state_q == DATA || state_q == STOP)) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            if (state_q == ARMED && fall_c) begin
                busy <= 1'b1;
            end

            if (state_q == START && half_c) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
                if (rx_s) begin
                    busy <= 1'b0;
                end
            end

            if (state_q == DATA && wrap_c) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            end

            if (state_q == PARITY && wrap_c) begin
                perr_q <= parity_mismatch(MAX_DATA_BITS'(shift_q), rx_s, (PARITY_ODD != 0));
            end

            if (state_q == STOP && wrap_c) begin
                ferr_q <= ferr_q | ~rx_s;
                if (last_stop_c) begin
                    en_data_out <= 1'b1;
                    data_out    <= shift_q;
                    parity_err  <= perr_q;
                    frame_err   <= ferr_q | ~rx_s;
                    busy        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three instances (8N1, 8E1, 8N2),
// expected frames queued per lane at send time and compared on each strobe.
module tb_uart_rx_param;

    localparam int unsigned CPB  = 16;
    localparam int unsigned IDLE = 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res;
    logic rx0, rx1, rx2;

    logic [7:0] dout0, dout1, dout2;
    logic       en0, en1, en2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       busy0, busy1, busy2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1), .IDLE_BITS(IDLE)) dut0 (
        .clk(clk), .res(res), .RX(rx0), .data_out(dout0), .en_data_out(en0),
        .parity_err(pe0), .frame_err(fe0), .busy(busy0));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .IDLE_BITS(IDLE)) dut1 (
        .clk(clk), .res(res), .RX(rx1), .data_out(dout1), .en_data_out(en1),
        .parity_err(pe1), .frame_err(fe1), .busy(busy1));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2), .IDLE_BITS(IDLE)) dut2 (
        .clk(clk), .res(res), .RX(rx2), .data_out(dout2), .en_data_out(en2),
        .parity_err(pe2), .frame_err(fe2), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int lane, input logic v);
        case (lane)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic send_bit(input int lane, input logic v);
        drive(lane, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int lane, input int n);
        for (int i = 0; i < n; i++) send_bit(lane, 1'b1);
    endtask

    task automatic send_frame(input int lane, input logic [7:0] d, input logic par_en,
                              input logic par_v, input logic stop_v, input int nstop,
                              input logic push, input logic eperr, input logic eferr);
        exp_t e;
        if (push) begin
            e.data = d;
            e.perr = eperr;
            e.ferr = eferr;
            case (lane)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        send_bit(lane, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(lane, d[i]);
        if (par_en) send_bit(lane, par_v);
        for (int i = 0; i < nstop; i++) send_bit(lane, stop_v);
    endtask

    // Scoreboard monitors: one per lane, compare on strobe.
    exp_t m0, m1, m2;
    always @(negedge clk) begin
        if (en0) begin
            if (q0.size() == 0) check("l0_spurious_strobe", en0, 0);
            else begin
                m0 = q0.pop_front();
                check("l0_data", dout0, m0.data);
                check("l0_perr", pe0, m0.perr);
                check("l0_ferr", fe0, m0.ferr);
            end
        end
    end
    always @(negedge clk) begin
        if (en1) begin
            if (q1.size() == 0) check("l1_spurious_strobe", en1, 0);
            else begin
                m1 = q1.pop_front();
                check("l1_data", dout1, m1.data);
                check("l1_perr", pe1, m1.perr);
                check("l1_ferr", fe1, m1.ferr);
            end
        end
    end
    always @(negedge clk) begin
        if (en2) begin
            if (q2.size() == 0) check("l2_spurious_strobe", en2, 0);
            else begin
                m2 = q2.pop_front();
                check("l2_data", dout2, m2.data);
                check("l2_perr", pe2, m2.perr);
                check("l2_ferr", fe2, m2.ferr);
            end
        end
    end

    initial begin
        logic seen;
        res = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", dout0, 0);
        check("rst_en", en0, 0);
        check("rst_busy", busy0, 0);
        check("rst_perr", pe0, 0);
        check("rst_ferr", fe0, 0);
        res = 1'b1;
        idle_bits(0, 4);

        // Plain 8N1 frame.
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(0, 1);

        // Short low glitch: busy pulses, then drops, no strobe.
        seen = 1'b0;
        for (int i = 0; i < 28; i++) begin
            rx0 = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            seen = seen | busy0;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_clear", busy0, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(0, 1);

        // Framing error, then an immediate frame that must be ignored until resync.
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle_bits(0, 4);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(0, 1);

        // Back-to-back frames, single stop bit.
        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        send_frame(0, 8'h80, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(0, 1);

        // Even parity: 0x37 has five ones, so parity bit 0 is wrong; 0xA5 with 0 is right.
        send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0);
        idle_bits(1, 1);
        send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1, 1);

        // Back-to-back frames with two stop bits.
        send_frame(2, 8'h01, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        send_frame(2, 8'h80, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        idle_bits(2, 1);

        // Reset during the data bits of 0x99: start, then bits 1,0,0.
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        res = 1'b0;
        rx0 = 1'b1;
        #1;
        check("midrst_data", dout0, 0);
        check("midrst_en", en0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_ferr", fe0, 0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        idle_bits(0, 4);
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(0, 2);

        check("l0_pending", q0.size(), 0);
        check("l1_pending", q1.size(), 0);
        check("l2_pending", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
